e203_nts_ctx_ctrl: RTL and testbench



---
 rtl/e203_nts_ctx_ctrl_if.sv | 24 ++
 rtl/e203_nts_ctx_ctrl.sv | 135 +++++++++++++
 tb/tb_e203_nts_ctx_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/e203_nts_ctx_ctrl_if.sv
// NTS port of the ITCM general RAM: word-addressed, byte-masked, read data
// returned the cycle after a read access.
interface e203_nts_ctx_ctrl_if #(
   parameter int AW = 6,
   parameter int DW = 32,
   parameter int MW = 4
);
   logic          cs_nts;
   logic          we_nts;
   logic [AW-1:0] addr_nts;
   logic [MW-1:0] wem_nts;
   logic [DW-1:0] din_nts;
   logic [DW-1:0] dout_nts;

   modport master (
      output cs_nts, we_nts, addr_nts, wem_nts, din_nts,
      input  dout_nts
   );

   modport slave (
      input  cs_nts, we_nts, addr_nts, wem_nts, din_nts,
      output dout_nts
   );
endinterface

// File: rtl/e203_nts_ctx_ctrl.sv
// Interrupt context save/restore engine: streams a block of integer registers
// into the NTS RAM on irq and back into the register file on mret.
module e203_nts_ctx_ctrl #(
   parameter int NREG      = 15,
   parameter int FIRST_REG = 1,
   parameter int AW        = 6,
   parameter int DW        = 32,
   parameter int MW        = 4,
   parameter int BASE      = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  irq_i,
   input  logic                  mret_i,
   output logic                  busy,
   output logic                  irq_s_reg_done,
   output logic                  mret2ram,
   output logic [4:0]            rf_raddr,
   input  logic [DW-1:0]         rf_rdata,
   output logic                  rf_wen,
   output logic [4:0]            rf_waddr,
   output logic [DW-1:0]         rf_wdata,
   e203_nts_ctx_ctrl_if.master   nts
);

   localparam int CW = $clog2(NREG + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAVE    = 3'd1,
      S_DONE  = 3'd2,
      RESTORE = 3'd3,
      R_DONE  = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          pend_s, pend_s_n;
   logic          pend_r, pend_r_n;
   logic [AW-1:0] slot_addr;
   logic [4:0]    slot_reg;

   assign slot_addr = AW'(BASE) + AW'(cnt);
   assign slot_reg  = 5'(FIRST_REG) + 5'(cnt);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         pend_s <= 1'b0;
         pend_r <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         pend_s <= pend_s_n;
         pend_r <= pend_r_n;
      end
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      pend_s_n       = pend_s | irq_i;
      pend_r_n       = pend_r | mret_i;
      irq_s_reg_done = 1'b0;
      mret2ram       = 1'b0;
      rf_raddr       = '0;
      rf_wen         = 1'b0;
      rf_waddr       = '0;
      rf_wdata       = '0;
      nts.cs_nts     = 1'b0;
      nts.we_nts     = 1'b0;
      nts.addr_nts   = '0;
      nts.wem_nts    = '0;
      nts.din_nts    = '0;

      case (state)
         IDLE: begin
            // Save wins over restore; a flag is consumed on entry to its state.
            if (pend_s || irq_i) begin
               state_n  = SAVE;
               pend_s_n = 1'b0;
               cnt_n    = '0;
            end else if (pend_r || mret_i) begin
               state_n  = RESTORE;
               pend_r_n = 1'b0;
               cnt_n    = '0;
            end
         end
         SAVE: begin
            nts.cs_nts   = 1'b1;
            nts.we_nts   = 1'b1;
            nts.wem_nts  = '1;
            nts.addr_nts = slot_addr;
            rf_raddr     = slot_reg;
            nts.din_nts  = rf_rdata;
            if (cnt == CW'(NREG - 1)) begin
               state_n = S_DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_DONE: begin
            irq_s_reg_done = 1'b1;
            state_n        = IDLE;
         end
         RESTORE: begin
            // Read of slot i overlaps the register write of slot i-1.
            if (cnt != CW'(NREG)) begin
               nts.cs_nts   = 1'b1;
               nts.addr_nts = slot_addr;
            end
            if (cnt != '0) begin
               rf_wen   = 1'b1;
               rf_waddr = slot_reg - 5'd1;
               rf_wdata = nts.dout_nts;
            end
            if (cnt == CW'(NREG)) begin
               state_n = R_DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         R_DONE: begin
            mret2ram = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_e203_nts_ctx_ctrl.sv
// Directed bench for the NTS context save/restore engine with a RAM model
// and a register file whose read data is 0xA000_0000 + index.
module tb_e203_nts_ctx_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        irq_i = 1'b0;
   logic        mret_i = 1'b0;
   logic        busy, irq_s_reg_done, mret2ram, rf_wen;
   logic [4:0]  rf_raddr, rf_waddr;
   logic [31:0] rf_rdata, rf_wdata;
   logic [31:0] mem [64];

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   e203_nts_ctx_ctrl_if #(.AW(6), .DW(32), .MW(4)) nts ();

   e203_nts_ctx_ctrl #(
      .NREG(15), .FIRST_REG(1), .AW(6), .DW(32), .MW(4), .BASE(0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .irq_i          (irq_i),
      .mret_i         (mret_i),
      .busy           (busy),
      .irq_s_reg_done (irq_s_reg_done),
      .mret2ram       (mret2ram),
      .rf_raddr       (rf_raddr),
      .rf_rdata       (rf_rdata),
      .rf_wen         (rf_wen),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .nts            (nts)
   );

   always #5 clk = ~clk;

   assign rf_rdata = 32'hA000_0000 + {27'd0, rf_raddr};

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      nts.dout_nts = '0;
   end

   always @(posedge clk) begin
      if (nts.cs_nts) begin
         if (nts.we_nts) begin
            for (int b = 0; b < 4; b++)
               if (nts.wem_nts[b]) mem[nts.addr_nts][8*b +: 8] <= nts.din_nts[8*b +: 8];
         end else begin
            nts.dout_nts <= mem[nts.addr_nts];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {busy, irq_s_reg_done, mret2ram, rf_wen, nts.cs_nts, nts.we_nts}, 0);
      chk({tag, "_idx"}, {rf_raddr, rf_waddr, nts.addr_nts, nts.wem_nts}, 0);
      chk({tag, "_wdata"}, rf_wdata, 0);
      chk({tag, "_din"}, nts.din_nts, 0);
   endtask

   // Entered in SAVE slot 0; leaves one cycle after the done pulse.
   task automatic run_save(input int m1, input int m2);
      for (int i = 0; i < 15; i++) begin
         chk("save_ctl", {busy, nts.cs_nts, nts.we_nts, nts.wem_nts, rf_wen, irq_s_reg_done, mret2ram},
             {1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0});
         chk("save_addr", nts.addr_nts, i);
         chk("save_din", nts.din_nts, 32'hA000_0001 + i);
         mret_i = (i == m1) || (i == m2);
         step();
      end
      mret_i = 1'b0;
      chk("save_done", {busy, irq_s_reg_done, nts.cs_nts, rf_wen}, 4'b1100);
      step();
   endtask

   // Entered in RESTORE slot 0; leaves one cycle after the done pulse.
   task automatic run_restore();
      for (int k = 0; k < 16; k++) begin
         chk("rst_ctl", {busy, nts.cs_nts, nts.we_nts, rf_wen, irq_s_reg_done, mret2ram},
             {1'b1, (k < 15), 1'b0, (k >= 1), 1'b0, 1'b0});
         chk("rst_addr", nts.addr_nts, (k < 15) ? k : 0);
         chk("rst_waddr", rf_waddr, (k >= 1) ? k : 0);
         chk("rst_wdata", rf_wdata, (k >= 1) ? (32'hA000_0000 + k) : 0);
         step();
      end
      chk("rst_done", {busy, mret2ram, nts.cs_nts, rf_wen}, 4'b1100);
      step();
   endtask

   initial begin
      // Reset held with irq asserted must not leave a pending save.
      rst = 1'b1;
      irq_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_zero("reset");
      end
      rst = 1'b0;
      irq_i = 1'b0;
      step();
      chk_zero("post_reset");
      step();
      chk_zero("post_reset2");

      irq_i = 1'b1;
      step();
      irq_i = 1'b0;
      run_save(-1, -1);
      chk_zero("save_idle");
      chk("mem_slot0", mem[0], 32'hA000_0001);
      chk("mem_slot14", mem[14], 32'hA000_000F);

      mret_i = 1'b1;
      step();
      mret_i = 1'b0;
      run_restore();
      chk_zero("restore_idle");

      // Simultaneous requests: save first, one IDLE cycle, then restore.
      irq_i = 1'b1;
      mret_i = 1'b1;
      step();
      irq_i = 1'b0;
      mret_i = 1'b0;
      run_save(-1, -1);
      chk_zero("both_gap");
      step();
      run_restore();
      chk_zero("both_idle");
      step();
      chk_zero("both_idle2");

      // Two mret pulses during SAVE collapse into one restore.
      irq_i = 1'b1;
      step();
      irq_i = 1'b0;
      run_save(3, 7);
      chk_zero("dbl_gap");
      step();
      run_restore();
      chk_zero("dbl_idle");
      step();
      chk_zero("dbl_idle2");

      // Abort a save at slot 5.
      irq_i = 1'b1;
      step();
      irq_i = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("abort_at5", {nts.cs_nts, nts.addr_nts}, {1'b1, 6'd5});
      rst = 1'b1;
      step();
      chk_zero("abort");
      rst = 1'b0;
      step();
      chk_zero("abort_nodone");
      irq_i = 1'b1;
      step();
      irq_i = 1'b0;
      run_save(-1, -1);
      chk_zero("restart_idle");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
